conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
//   Streaming 3x3 sliding-window generator for a stride-1, unpadded convolution layer.
//   - Accepts one raster-order pixel per cycle.
//   - Holds the last two image rows in line buffers.
//   - Presents the nine taps of each complete 3x3 window in parallel.
//   Sits upstream of the 9-multiplier array. Its taps feed the multiplier array, whose
//   products go to adder_tree product_input0..8, so tap order matches product order.
// PARAMETERS
//   DATA_W  8   pixel width in bits
//   IMG_W   28  image width in pixels; must be >= 3
//   IMG_H   28  image height in pixels; must be >= 3
// PORTS
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   flush      in   1         synchronous abort of the current frame
//   in_valid   in   1         in_data carries a pixel this cycle
//   in_data    in   DATA_W    pixel, raster order (row-major, top-left first)
//   win0..win8 out  DATA_W    window taps, row-major: win0=top-left, win8=bottom-right
//   win_valid  out  1         win0..win8 hold a complete window this cycle
//   frame_done out  1         last window of the frame is presented this cycle
// BEHAVIOUR
//   - Reset (rst_n=0, async): col, row, window registers, win0..8, win_valid and
//     frame_done all go to 0. Line-buffer contents are don't-care.
//   - Accept: a pixel is accepted when in_valid=1 and flush=0. There is no backpressure.
//     Downstream is a fixed pipeline and must consume every win_valid cycle.
//   - Counters: col counts 0..IMG_W-1 and row counts 0..IMG_H-1 for the accepted pixel.
//     col wraps to 0 and row increments at end of line. Both wrap to 0 after pixel
//     (IMG_H-1, IMG_W-1), so the next accepted pixel starts a new frame with no idle
//     cycle required.
//   - Line buffers: lb1 holds row r-2 and lb0 holds row r-1, each IMG_W entries, indexed
//     by col. On accept at column c:
//     - new tap column = {lb1[c], lb0[c], in_data} (top to bottom);
//     - lb1[c] <= lb0[c], lb0[c] <= in_data.
//   - Window: a 3x3 register array shifts left by one column on every accept, and the
//     new tap column enters at the right. win0..8 are registered outputs of this array.
//   - Latency: 1 cycle. An accepted pixel at (row>=2, col>=2) gives win_valid=1 on the
//     next cycle, with win8 equal to that pixel.
//   - Stale taps: windows spanning a row wrap are never flagged valid. This is what the
//     col>=2 gating guarantees.
//   - Cycles with no accept: window registers and counters hold. win_valid and frame_done
//     are 0 on the following cycle. Gaps of any length are allowed anywhere.
//   - frame_done: pulses high for one cycle, together with win_valid, for the window
//     built from pixel (IMG_H-1, IMG_W-1).
//   - Window count: exactly (IMG_W-2)*(IMG_H-2) win_valid pulses per frame.
//   - flush=1: col and row clear to 0 at the next edge. win_valid and frame_done are 0
//     on the next cycle. in_data that cycle is ignored. Line buffers need not be cleared.
//   - Mid-operation reset: the next frame starts at (0,0). No window from the aborted
//     frame is ever emitted.
//   - Arithmetic: none on pixel data. Taps are bit-exact copies of input pixels.
// TESTING (IMG_W=5, IMG_H=5, pixel value = raster index + 1)
//   1. Reset: hold rst_n=0 -> all outputs 0. Release, then stream 25 pixels
//      back-to-back -> exactly 9 win_valid pulses.
//   2. First window: win_valid rises the cycle after pixel 13 is accepted
//      -> win0..8 = 1,2,3,6,7,8,11,12,13.
//   3. Last window: the cycle after pixel 25 -> taps 13,14,15,18,19,20,23,24,25 and
//      frame_done=1. frame_done=0 on all other cycles.
//   4. Random in_valid gaps (~40% idle) on the same frame -> the same 9 windows in the
//      same order. win_valid is never high the cycle after an idle cycle.
//   5. Two frames back-to-back, second frame values +100 -> the second frame's first
//      window is 101,102,103,106,107,108,111,112,113, with no frame-1 taps mixed in.
//   6. Async reset after pixel 17, then flush after pixel 8 of a fresh frame, each
//      followed by a full frame -> no win_valid before the restart, then 9 correct
//      windows.

Source files
------------

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle for conv_window_gen.
//   master : pixel source and window consumer (drives flush, in_valid, in_data)
//   slave  : window generator (drives win0..win8, win_valid, frame_done)
interface conv_window_gen_if #(
  parameter int unsigned DATA_W = 8
);
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic              win_valid;
  logic              frame_done;

  modport master (
    output flush, in_valid, in_data,
    input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
    input  win_valid, frame_done
  );

  modport slave (
    input  flush, in_valid, in_data,
    output win0, win1, win2, win3, win4, win5, win6, win7, win8,
    output win_valid, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator, stride 1, no padding.
// Takes one raster-order pixel per accepted cycle, keeps the two previous rows
// in line buffers and presents the nine taps of each complete window in parallel.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus.slave   flush / in_valid / in_data in; win0..win8 (row-major,
//               win0 = top-left), win_valid, frame_done out, all registered
module conv_window_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_window_gen_if.slave bus
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned NTAPS = 9;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] lb0 [IMG_W];   // row r-1
  logic [DATA_W-1:0] lb1 [IMG_W];   // row r-2
  logic [DATA_W-1:0] win_q [NTAPS];
  logic              win_valid_q;
  logic              frame_done_q;

  logic              accept_c;
  logic              last_col_c;
  logic              last_row_c;
  logic              full_win_c;
  logic [DATA_W-1:0] top_c;
  logic [DATA_W-1:0] mid_c;

  // Accept qualification and position decode for the pixel on the bus
  always_comb begin
    accept_c   = bus.in_valid && !bus.flush;
    last_col_c = (col == COL_W'(IMG_W - 1));
    last_row_c = (row == ROW_W'(IMG_H - 1));
    // col>=2 gating keeps windows that straddle a row wrap from being flagged
    full_win_c = (row >= ROW_W'(2)) && (col >= COL_W'(2));
    top_c      = lb1[col];
    mid_c      = lb0[col];
  end

  // Raster position counters; wrap straight into the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.flush) begin
      col <= '0;
      row <= '0;
    end else if (accept_c) begin
      if (last_col_c) begin
        col <= '0;
        row <= last_row_c ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Line buffers: contents are don't-care after reset, so no reset branch
  always_ff @(posedge clk) begin
    if (accept_c) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.in_data;
    end
  end

  // Window array shifts left; new tap column enters on the right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) win_q[i] <= '0;
    end else if (accept_c) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= top_c;
      win_q[3] <= win_q[4];
      win_q[4] <= win_q[5];
      win_q[5] <= mid_c;
      win_q[6] <= win_q[7];
      win_q[7] <= win_q[8];
      win_q[8] <= bus.in_data;
    end
  end

  // Window strobes; low after any non-accept cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= accept_c && full_win_c;
      frame_done_q <= accept_c && last_col_c && last_row_c;
    end
  end

  assign bus.win0       = win_q[0];
  assign bus.win1       = win_q[1];
  assign bus.win2       = win_q[2];
  assign bus.win3       = win_q[3];
  assign bus.win4       = win_q[4];
  assign bus.win5       = win_q[5];
  assign bus.win6       = win_q[6];
  assign bus.win7       = win_q[7];
  assign bus.win8       = win_q[8];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on a 5x5 frame, pixel = raster index + 1.
module tb_conv_window_gen;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IMG_W  = 5;
  localparam int unsigned IMG_H  = 5;
  localparam int unsigned NWIN   = 9;

  // trig = pixel value whose accept produces the window
  typedef struct packed {
    logic [7:0]      trig;
    logic [8:0][7:0] taps;
    logic            fd;
  } vec_t;

  vec_t tbl [NWIN];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_gen_if #(.DATA_W(DATA_W)) bus ();

  conv_window_gen #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks   = 0;
  int         errors   = 0;
  int         win_cnt  = 0;
  int         step     = 0;
  logic       prev_acc = 1'b0;
  logic [7:0] prev_pix = 8'd0;

  function automatic vec_t mk(input int trig, input int a, input int b, input int c,
                              input int d, input int e, input int f, input int g,
                              input int h, input int i, input logic fd);
    vec_t v;
    v.trig    = 8'(trig);
    v.taps[0] = 8'(a); v.taps[1] = 8'(b); v.taps[2] = 8'(c);
    v.taps[3] = 8'(d); v.taps[4] = 8'(e); v.taps[5] = 8'(f);
    v.taps[6] = 8'(g); v.taps[7] = 8'(h); v.taps[8] = 8'(i);
    v.fd      = fd;
    return v;
  endfunction

  function automatic logic [8:0][7:0] got_taps();
    return {bus.win8, bus.win7, bus.win6, bus.win5, bus.win4,
            bus.win3, bus.win2, bus.win1, bus.win0};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Output monitor: inputs seen at this negedge are captured on the next posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_acc = 1'b0;
    end else begin
      if (!prev_acc) begin
        checks++;
        if (bus.win_valid || bus.frame_done) begin
          errors++;
          $display("FAIL no_accept_strobe win_valid=%0b frame_done=%0b exp=0",
                   bus.win_valid, bus.frame_done);
        end
      end else if (bus.win_valid) begin
        int idx, off;
        logic [8:0][7:0] exp_t;
        idx = win_cnt % NWIN;
        off = (win_cnt / NWIN) * step;
        for (int i = 0; i < 9; i++) exp_t[i] = tbl[idx].taps[i] + 8'(off);
        checks++;
        if (got_taps() != exp_t) begin
          errors++;
          $display("FAIL win_taps n=%0d got=%h exp=%h", win_cnt, got_taps(), exp_t);
        end
        chk("frame_done", int'(bus.frame_done), int'(tbl[idx].fd));
        chk("trig_pixel", int'(prev_pix), int'(tbl[idx].trig + 8'(off)));
        win_cnt++;
      end else begin
        chk("frame_done_idle", int'(bus.frame_done), 0);
      end
      prev_acc = bus.in_valid && !bus.flush;
      prev_pix = bus.in_data;
    end
  end

  task automatic cycle(input logic v, input logic [7:0] d, input logic fl);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'hEE, 1'b0);
  endtask

  task automatic pixels(input int off, input int npix, input int idle_pct);
    for (int p = 0; p < npix; p++) begin
      int gaps = 0;
      while (gaps < 4 && int'($urandom_range(99, 0)) < idle_pct) begin
        cycle(1'b0, 8'hA5, 1'b0);
        gaps++;
      end
      cycle(1'b1, 8'(p + 1 + off), 1'b0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_win_valid"},  int'(bus.win_valid), 0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
    chk({tag, "_taps"}, (got_taps() == '0) ? 0 : 1, 0);
  endtask

  initial begin
    tbl[0] = mk(13,  1,  2,  3,  6,  7,  8, 11, 12, 13, 1'b0);
    tbl[1] = mk(14,  2,  3,  4,  7,  8,  9, 12, 13, 14, 1'b0);
    tbl[2] = mk(15,  3,  4,  5,  8,  9, 10, 13, 14, 15, 1'b0);
    tbl[3] = mk(18,  6,  7,  8, 11, 12, 13, 16, 17, 18, 1'b0);
    tbl[4] = mk(19,  7,  8,  9, 12, 13, 14, 17, 18, 19, 1'b0);
    tbl[5] = mk(20,  8,  9, 10, 13, 14, 15, 18, 19, 20, 1'b0);
    tbl[6] = mk(23, 11, 12, 13, 16, 17, 18, 21, 22, 23, 1'b0);
    tbl[7] = mk(24, 12, 13, 14, 17, 18, 19, 22, 23, 24, 1'b0);
    tbl[8] = mk(25, 13, 14, 15, 18, 19, 20, 23, 24, 25, 1'b1);

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.flush    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Back-to-back frame: first/last window and count
    win_cnt = 0;
    pixels(0, 25, 0);
    idle(2);
    chk("count_b2b", win_cnt, 9);

    // Random idle gaps
    win_cnt = 0;
    pixels(0, 25, 40);
    idle(2);
    chk("count_gaps", win_cnt, 9);

    // Two frames with no gap, second offset by 100
    win_cnt = 0;
    step    = 100;
    pixels(0, 25, 0);
    pixels(100, 25, 0);
    idle(2);
    chk("count_two_frames", win_cnt, 18);
    step = 0;

    // Async reset mid-frame after pixel 17
    win_cnt = 0;
    pixels(0, 17, 0);
    chk("count_partial", win_cnt, 3);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    win_cnt = 0;
    idle(2);
    chk("count_after_reset", win_cnt, 0);
    pixels(0, 25, 0);
    idle(2);
    chk("count_post_reset", win_cnt, 9);

    // Flush after pixel 8 of a fresh frame
    win_cnt = 0;
    pixels(0, 8, 0);
    cycle(1'b1, 8'h55, 1'b1);
    idle(1);
    chk("count_before_restart", win_cnt, 0);
    pixels(0, 25, 0);
    idle(2);
    chk("count_post_flush", win_cnt, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
